match_event_tracker: RTL and testbench

Downstream consumer of the Mealy 11011 non-overlapping sequence detector. It takes the detector's 1-bit match output and turns it into observable statistics:
- a saturating match count
- the cycle gap between the last two matches
- a sticky overflow flag
- a stretched LED pulse

It sits between the detector instance and the top-level `uo_out` pins, and selects one statistic onto an 8-bit bus.

---
 rtl/match_tracker_pkg.sv | 29 ++
 rtl/pulse_stretcher.sv | 32 +++
 rtl/match_event_tracker.sv | 131 +++++++++++++
 tb/tb_match_event_tracker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_tracker_pkg.sv
// Shared types and constants for the match event tracker: gap FSM states,
// stat_out view encodings and the counter saturation value.
package match_tracker_pkg;

   // Default statistics width used by the top-level build.
   localparam int unsigned DEF_CNT_W = 8;

   // All-ones value of a w-bit counter, used as the saturation point.
   function automatic int unsigned cnt_max(input int unsigned w);
      return (1 << w) - 1;
   endfunction

   localparam int unsigned CNT_MAX = cnt_max(DEF_CNT_W);

   // Gap FSM: IDLE until the first hit, then TIMING forever (until clear/rst).
   typedef enum logic {
      IDLE   = 1'b0,
      TIMING = 1'b1
   } gap_state_e;

   // stat_out view selection.
   typedef enum logic [1:0] {
      SEL_COUNT = 2'b00,
      SEL_GAP   = 2'b01,
      SEL_FLAGS = 2'b10,
      SEL_RUN   = 2'b11
   } sel_view_e;

endpackage

// File: rtl/pulse_stretcher.sv
// Retriggerable pulse stretcher: a trig pulse holds out high for exactly
// STRETCH_CYC cycles; a new trig during the hold restarts the full length.
module pulse_stretcher #(
   parameter int unsigned STRETCH_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic trig,
   output logic out
);

   localparam int unsigned SW = $clog2(STRETCH_CYC + 1);

   logic [SW-1:0] stretch_cnt;

   // Load on trig, otherwise count down to zero; clear wins over trig.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stretch_cnt <= '0;
      end else if (clear) begin
         stretch_cnt <= '0;
      end else if (trig) begin
         stretch_cnt <= SW'(STRETCH_CYC);
      end else if (stretch_cnt != '0) begin
         stretch_cnt <= stretch_cnt - SW'(1);
      end
   end

   assign out = (stretch_cnt != '0);

endmodule

// File: rtl/match_event_tracker.sv
// Match event tracker: turns the 11011 detector's match output into a
// saturating match count, last inter-match gap, sticky overflow flag and a
// stretched LED pulse, with one statistic muxed onto stat_out.
module match_event_tracker
   import match_tracker_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned STRETCH_CYC = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       match_in,
   input  logic       clear,
   input  logic [1:0] sel,
   output logic [7:0] stat_out,
   output logic       led,
   output logic       overflow
);

   localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_max(CNT_W));

   logic             match_d;
   logic             hit;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] gap_q,   gap_d;
   logic [CNT_W-1:0] run_q,   run_d;
   gap_state_e       state_q, state_d;

   // Previous-cycle copy of match_in for rising-edge detection; keeps
   // sampling during clear so a held match is not recounted afterwards.
   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_d <= 1'b0;
      end else begin
         match_d <= match_in;
      end
   end

   // A long-high match_in produces a single one-cycle hit.
   assign hit = match_in & ~match_d;

   // Saturating match counter; a hit at saturation raises sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (hit) begin
         if (count == SAT) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   // Gap FSM state and timing registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gap_q   <= '0;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         run_q   <= run_d;
      end
   end

   // Gap FSM next state: the running count starts at 1 on a hit so that a
   // hit k cycles later captures exactly k; it saturates at SAT.
   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      run_d   = run_q;
      if (clear) begin
         state_d = IDLE;
         gap_d   = '0;
         run_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  state_d = TIMING;
                  run_d   = CNT_W'(1);
               end
            end
            TIMING: begin
               if (hit) begin
                  gap_d = run_q;
                  run_d = CNT_W'(1);
               end else if (run_q != SAT) begin
                  run_d = run_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   pulse_stretcher #(
      .STRETCH_CYC (STRETCH_CYC)
   ) u_stretch (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .trig  (hit),
      .out   (led)
   );

   // Zero-latency view select onto the output bus.
   always_comb begin
      stat_out = '0;
      case (sel_view_e'(sel))
         SEL_COUNT: stat_out = 8'(count);
         SEL_GAP:   stat_out = 8'(gap_q);
         SEL_FLAGS: stat_out = {overflow, state_q == TIMING, led, 5'b0};
         SEL_RUN:   stat_out = 8'(run_q);
         default:   stat_out = '0;
      endcase
   end

endmodule

// File: tb/tb_match_event_tracker.sv
// Directed self-checking bench for match_event_tracker (default parameters:
// CNT_W=8, STRETCH_CYC=8). Inputs change 1 ns after the rising edge and
// outputs are sampled in the same window, away from the edge.
module tb_match_event_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       match_in;
   logic       clear;
   logic [1:0] sel;
   logic [7:0] stat_out;
   logic       led;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   match_event_tracker dut (
      .clk      (clk),
      .rst      (rst),
      .match_in (match_in),
      .clear    (clear),
      .sel      (sel),
      .stat_out (stat_out),
      .led      (led),
      .overflow (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic view(input logic [1:0] v);
      sel = v;
      #1;
   endtask

   // match_in high for len cycles starting now; returns one cycle after the
   // first rising edge plus len-1 further cycles.
   task automatic pulse(input int len);
      match_in = 1'b1;
      repeat (len) tick();
      match_in = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      match_in = 1'b0;
      clear    = 1'b0;
      sel      = 2'b00;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      match_in = 1'b0;
      clear    = 1'b0;
      #2;
      for (int s = 0; s < 4; s++) begin
         view(2'(s));
         n_checks++;
         if (stat_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_stat_out sel=%0d got %h expected 00", s, stat_out);
         end
      end
      n_checks++;
      if (led !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_led got %b expected 0", led);
      end
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_overflow got %b expected 0", overflow);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_match();
      do_reset();
      repeat (6) tick();
      pulse(1);
      view(2'b00);
      n_checks++;
      if (stat_out !== 8'd1) begin
         n_fail++;
         $display("FAIL single_count got %0d expected 1", stat_out);
      end
      view(2'b10);
      for (int k = 1; k <= 8; k++) begin
         n_checks++;
         if (led !== 1'b1 || stat_out !== 8'h60) begin
            n_fail++;
            $display("FAIL single_led_on k=%0d led=%b flags=%h expected led=1 flags=60", k, led, stat_out);
         end
         tick();
      end
      n_checks++;
      if (led !== 1'b0 || stat_out !== 8'h40) begin
         n_fail++;
         $display("FAIL single_led_off led=%b flags=%h expected led=0 flags=40", led, stat_out);
      end
   endtask

   task automatic test_gap();
      do_reset();
      pulse(1);
      repeat (16) tick();
      view(2'b11);
      n_checks++;
      if (stat_out !== 8'd17) begin
         n_fail++;
         $display("FAIL gap_run_before_hit got %0d expected 17", stat_out);
      end
      pulse(1);
      view(2'b01);
      n_checks++;
      if (stat_out !== 8'd17) begin
         n_fail++;
         $display("FAIL gap_17 got %0d expected 17", stat_out);
      end
      view(2'b00);
      n_checks++;
      if (stat_out !== 8'd2) begin
         n_fail++;
         $display("FAIL gap_count got %0d expected 2", stat_out);
      end
      // Held-high match: counted once.
      tick();
      pulse(5);
      n_checks++;
      if (stat_out !== 8'd3) begin
         n_fail++;
         $display("FAIL long_match_count got %0d expected 3", stat_out);
      end
      repeat (3) tick();
      n_checks++;
      if (stat_out !== 8'd3) begin
         n_fail++;
         $display("FAIL long_match_count_later got %0d expected 3", stat_out);
      end
      view(2'b01);
      n_checks++;
      if (stat_out !== 8'd2) begin
         n_fail++;
         $display("FAIL long_match_gap got %0d expected 2", stat_out);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 255; i++) begin
         pulse(1);
         tick();
      end
      view(2'b00);
      n_checks++;
      if (stat_out !== 8'd255 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_255 count=%0d ovf=%b expected 255/0", stat_out, overflow);
      end
      pulse(1);
      n_checks++;
      if (stat_out !== 8'd255 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_256 count=%0d ovf=%b expected 255/1", stat_out, overflow);
      end
      view(2'b10);
      n_checks++;
      if (stat_out[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_flags_bit7 flags=%h expected bit7=1", stat_out);
      end
      tick();
      pulse(1);
      view(2'b00);
      n_checks++;
      if (stat_out !== 8'd255 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_257 count=%0d ovf=%b expected 255/1", stat_out, overflow);
      end
      view(2'b01);
      n_checks++;
      if (stat_out !== 8'd2) begin
         n_fail++;
         $display("FAIL sat_gap got %0d expected 2", stat_out);
      end
   endtask

   // Runs straight after test_saturation: overflow set, led active, gap=2.
   task automatic test_clear_priority();
      tick();
      view(2'b10);
      n_checks++;
      if (stat_out !== 8'he0) begin
         n_fail++;
         $display("FAIL clear_precond flags=%h expected e0", stat_out);
      end
      clear    = 1'b1;
      match_in = 1'b1;
      tick();
      clear    = 1'b0;
      match_in = 1'b0;
      for (int s = 0; s < 4; s++) begin
         view(2'(s));
         n_checks++;
         if (stat_out !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_stat sel=%0d got %h expected 00", s, stat_out);
         end
      end
      n_checks++;
      if (led !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_led_ovf led=%b ovf=%b expected 0/0", led, overflow);
      end
      tick();
      pulse(1);
      view(2'b00);
      n_checks++;
      if (stat_out !== 8'd1) begin
         n_fail++;
         $display("FAIL clear_next_count got %0d expected 1", stat_out);
      end
      view(2'b01);
      n_checks++;
      if (stat_out !== 8'd0) begin
         n_fail++;
         $display("FAIL clear_next_gap got %0d expected 0", stat_out);
      end
      view(2'b11);
      n_checks++;
      if (stat_out !== 8'd1) begin
         n_fail++;
         $display("FAIL clear_next_run got %0d expected 1", stat_out);
      end
      view(2'b10);
      n_checks++;
      if (stat_out !== 8'h60) begin
         n_fail++;
         $display("FAIL clear_next_flags got %h expected 60", stat_out);
      end
   endtask

   task automatic test_gap_cap();
      do_reset();
      pulse(1);
      repeat (299) tick();
      view(2'b11);
      n_checks++;
      if (stat_out !== 8'd255) begin
         n_fail++;
         $display("FAIL gap_cap_run got %0d expected 255", stat_out);
      end
      pulse(1);
      view(2'b01);
      n_checks++;
      if (stat_out !== 8'd255) begin
         n_fail++;
         $display("FAIL gap_cap got %0d expected 255", stat_out);
      end
      view(2'b11);
      n_checks++;
      if (stat_out !== 8'd1) begin
         n_fail++;
         $display("FAIL gap_cap_run_restart got %0d expected 1", stat_out);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      view(2'b00);
      pulse(1);
      repeat (2) tick();
      n_checks++;
      if (led !== 1'b1 || stat_out !== 8'd1) begin
         n_fail++;
         $display("FAIL async_precond led=%b count=%0d expected 1/1", led, stat_out);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (led !== 1'b0 || stat_out !== 8'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset led=%b count=%0d ovf=%b expected 0/0/0", led, stat_out, overflow);
      end
      view(2'b10);
      n_checks++;
      if (stat_out !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset_flags got %h expected 00", stat_out);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_match();
      test_gap();
      test_saturation();
      test_clear_priority();
      test_gap_cap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
